// File: rtl/command_entry_pkg.sv
// Shared widths, field-select encodings and FSM state codes for the operator
// command-entry front end.
package command_entry_pkg;

    localparam int CMD_ADDR_W = 5;
    localparam int CMD_OP_W   = 7;
    localparam int CMD_WORD_W = CMD_ADDR_W + CMD_OP_W;

    localparam logic FIELD_ADDR = 1'b0;
    localparam logic FIELD_CMD  = 1'b1;

    typedef enum logic {
        ST_EDIT    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/command_entry_btn_debounce.sv
// Two-flop synchronizer plus hold-time debouncer for one raw push-button;
// emits a single-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             synced;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            synced  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            synced  <= sync1;
            level_q <= level;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // level has disagreed for the full hold window: accept it
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/command_entry.sv
// Builds {address, command} from debounced buttons and offers the finished
// word downstream over a registered valid/ready handshake.
module command_entry
    import command_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDR_W          = CMD_ADDR_W,
    parameter int CMD_W           = CMD_OP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_field,
    input  logic                      btn_load,
    input  logic                      btn_inc,
    input  logic                      btn_dec,
    input  logic                      btn_submit,
    input  logic [CMD_W-1:0]          sw_value,
    output logic [ADDR_W+CMD_W-1:0]   cmd_buf,
    output logic                      field_sel,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [ADDR_W+CMD_W-1:0]   cmd_out
);

    // bit order: 0 field, 1 load, 2 inc, 3 dec, 4 submit
    logic [4:0] raw_btn;
    logic [4:0] press;
    logic [4:0] btn_level_unused;

    assign raw_btn = {btn_submit, btn_dec, btn_inc, btn_load, btn_field};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .level(btn_level_unused[i]),
            .press(press[i])
        );
    end

    state_t                    state, state_n;
    logic [ADDR_W-1:0]         addr, addr_n;
    logic [CMD_W-1:0]          op, op_n;
    logic                      field_n;
    logic                      valid_n;
    logic [ADDR_W+CMD_W-1:0]   out_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EDIT;
            addr      <= '0;
            op        <= '0;
            field_sel <= FIELD_ADDR;
            cmd_valid <= 1'b0;
            cmd_out   <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            op        <= op_n;
            field_sel <= field_n;
            cmd_valid <= valid_n;
            cmd_out   <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        op_n    = op;
        field_n = field_sel;
        valid_n = cmd_valid;
        out_n   = cmd_out;
        case (state)
            ST_EDIT: begin
                if (press[4]) begin
                    out_n   = {addr, op};
                    valid_n = 1'b1;
                    state_n = ST_PENDING;
                end else if (press[0]) begin
                    field_n = ~field_sel;
                end else if (press[1]) begin
                    if (field_sel == FIELD_CMD) op_n = sw_value;
                    else                        addr_n = sw_value[ADDR_W-1:0];
                end else if (press[2] ^ press[3]) begin
                    // natural width overflow gives the required wrap-around
                    if (field_sel == FIELD_CMD) op_n = press[2] ? op + 1'b1 : op - 1'b1;
                    else                        addr_n = press[2] ? addr + 1'b1 : addr - 1'b1;
                end
            end
            ST_PENDING: begin
                if (cmd_ready) begin
                    valid_n = 1'b0;
                    state_n = ST_EDIT;
                end
            end
            default: state_n = ST_EDIT;
        endcase
    end

    assign cmd_buf = {addr, op};

endmodule

// File: tb/tb_command_entry.sv
// Self-checking bench for command_entry: directed spec scenarios followed by
// randomized button/ready traffic, checked against a field-level model.
module tb_command_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_field = 1'b0, btn_load = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_submit = 1'b0;
    logic [6:0]  sw_value = 7'h00;
    logic        cmd_ready = 1'b0;
    logic [11:0] cmd_buf;
    logic        field_sel;
    logic        cmd_valid;
    logic [11:0] cmd_out;

    command_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_field (btn_field),
        .btn_load  (btn_load),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_submit(btn_submit),
        .sw_value  (sw_value),
        .cmd_buf   (cmd_buf),
        .field_sel (field_sel),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_out   (cmd_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: plain field values
    int m_addr, m_cmd, m_field, m_valid, m_out;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cmd_buf"},   cmd_buf,            12'(m_addr * 128 + m_cmd));
        check({tag, ".field_sel"}, {11'd0, field_sel}, 12'(m_field));
        check({tag, ".cmd_valid"}, {11'd0, cmd_valid}, 12'(m_valid));
        check({tag, ".cmd_out"},   cmd_out,            12'(m_out));
    endtask

    task automatic model_reset();
        m_addr = 0; m_cmd = 0; m_field = 0; m_valid = 0; m_out = 0;
    endtask

    task automatic model_press(input logic [4:0] m);
        if (m_valid == 0) begin
            if (m[4]) begin
                m_out   = m_addr * 128 + m_cmd;
                m_valid = 1;
            end else if (m[0]) begin
                m_field = 1 - m_field;
            end else if (m[1]) begin
                if (m_field == 1) m_cmd = int'(sw_value);
                else              m_addr = int'(sw_value) % 32;
            end else if (m[2] && !m[3]) begin
                if (m_field == 1) m_cmd = (m_cmd + 1) % 128;
                else              m_addr = (m_addr + 1) % 32;
            end else if (m[3] && !m[2]) begin
                if (m_field == 1) m_cmd = (m_cmd + 127) % 128;
                else              m_addr = (m_addr + 31) % 32;
            end
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bits: 0 field, 1 load, 2 inc, 3 dec, 4 submit
    task automatic drive(input logic [4:0] m);
        btn_field  = m[0];
        btn_load   = m[1];
        btn_inc    = m[2];
        btn_dec    = m[3];
        btn_submit = m[4];
    endtask

    task automatic press(input logic [4:0] m);
        drive(m);
        wait_n(8);
        drive(5'b0);
        wait_n(8);
        model_press(m);
    endtask

    task automatic ready_pulse();
        cmd_ready = 1'b1;
        wait_n(1);
        cmd_ready = 1'b0;
        m_valid = 0;
    endtask

    initial begin
        logic [4:0] m;

        model_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_n(3);
        check_all("reset");
        rst = 1'b0;
        wait_n(2);

        for (int i = 0; i < 33; i++) press(5'b00100);
        check_all("inc33");
        check("inc33_word", cmd_buf, 12'h080);
        press(5'b01000);
        press(5'b01000);
        check_all("dec_wrap");
        check("dec_wrap_word", cmd_buf, 12'hF80);

        press(5'b00001);
        sw_value = 7'h55;
        press(5'b00010);
        check_all("load55");
        check("load55_cmd", {5'd0, cmd_buf[6:0]}, 12'h055);
        press(5'b01000);
        check("dec54_cmd", {5'd0, cmd_buf[6:0]}, 12'h054);
        sw_value = 7'h7F;
        press(5'b00010);
        press(5'b00100);
        check_all("inc_wrap_cmd");
        check("inc_wrap_cmd_val", {5'd0, cmd_buf[6:0]}, 12'h000);

        drive(5'b00100);
        wait_n(3);
        drive(5'b0);
        wait_n(12);
        check_all("glitch3");

        drive(5'b00100);
        wait_n(4);
        drive(5'b0);
        wait_n(2);
        check_all("edge6_unchanged");
        wait_n(1);
        model_press(5'b00100);
        check_all("edge7_updated");
        wait_n(10);

        drive(5'b00100);
        wait_n(100);
        drive(5'b0);
        wait_n(10);
        model_press(5'b00100);
        check_all("held100");

        press(5'b10000);
        check_all("submit");
        press(5'b00100);
        sw_value = 7'h2A;
        press(5'b00010);
        check_all("pending_frozen");
        ready_pulse();
        check_all("accept");
        press(5'b00100);
        check_all("inc_after_accept");

        ready_pulse();
        check_all("ready_in_edit");
        press(5'b01100);
        check_all("inc_dec_same");
        press(5'b10100);
        check_all("submit_plus_inc");

        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        model_reset();
        check_all("rst_pending");
        wait_n(2);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ready_pulse();
            end else begin
                sw_value = 7'($urandom);
                m = 5'($urandom);
                if (m[4] && $urandom_range(0, 2) != 0) m[4] = 1'b0;
                press(m);
            end
            check_all($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
